// File: rtl/johnson_sequence_checker.sv
// Receive-side checker for a 4-bit Johnson up counter: decodes each sampled
// code to a 0..7 index, tracks lock on the legal sequence and counts errors/wraps.
module johnson_sequence_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int CNT_WIDTH  = 8,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [3:0]           johnson_in,
  output logic [2:0]           index,
  output logic                 valid_code,
  output logic                 locked,
  output logic                 seq_error,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] wrap_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  state_t               state, state_next;
  logic [2:0]           prev, prev_next;
  logic [3:0]           run, run_next;
  logic                 seq_error_next;
  logic [CNT_WIDTH-1:0] err_count_next;
  logic [CNT_WIDTH-1:0] wrap_count_next;

  logic       legal;
  logic [2:0] decoded;
  logic       advance;
  logic       hold;
  logic [3:0] run_inc;

  always_comb begin
    legal   = 1'b1;
    decoded = 3'd0;
    case (johnson_in)
      4'b0000: decoded = 3'd0;
      4'b0001: decoded = 3'd1;
      4'b0011: decoded = 3'd2;
      4'b0111: decoded = 3'd3;
      4'b1111: decoded = 3'd4;
      4'b1110: decoded = 3'd5;
      4'b1100: decoded = 3'd6;
      4'b1000: decoded = 3'd7;
      default: legal   = 1'b0;
    endcase
  end

  // 3-bit addition wraps naturally, so 7->0 counts as a correct advance.
  assign advance = legal && (decoded == prev + 3'd1);
  assign hold    = legal && (decoded == prev);
  assign run_inc = run + 4'd1;

  always_comb begin
    state_next      = state;
    prev_next       = prev;
    run_next        = run;
    seq_error_next  = 1'b0;
    err_count_next  = err_count;
    wrap_count_next = wrap_count;

    if (sample_en) begin
      case (state)
        SEARCH: begin
          if (legal) begin
            prev_next  = decoded;
            run_next   = 4'd0;
            state_next = VERIFY;
          end
        end

        VERIFY: begin
          if (!legal) begin
            run_next   = 4'd0;
            state_next = SEARCH;
          end else if (advance) begin
            prev_next = decoded;
            if (run_inc == LOCK_TARGET) begin
              run_next   = 4'd0;
              state_next = LOCKED;
            end else begin
              run_next = run_inc;
            end
          end else if (hold && ALLOW_HOLD) begin
            run_next = run;
          end else begin
            run_next  = 4'd0;
            prev_next = decoded;
          end
        end

        LOCKED: begin
          if (advance) begin
            prev_next = decoded;
            if (prev == 3'd7) begin
              wrap_count_next = wrap_count + CNT_WIDTH'(1);
            end
          end else if (hold && ALLOW_HOLD) begin
            prev_next = prev;
          end else begin
            // The offending code is dropped; the next sample starts a fresh search.
            seq_error_next = 1'b1;
            if (err_count != {CNT_WIDTH{1'b1}}) begin
              err_count_next = err_count + CNT_WIDTH'(1);
            end
            run_next   = 4'd0;
            state_next = SEARCH;
          end
        end

        default: begin
          run_next   = 4'd0;
          state_next = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SEARCH;
      prev       <= 3'd0;
      run        <= 4'd0;
      index      <= 3'd0;
      valid_code <= 1'b0;
      seq_error  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state      <= state_next;
      prev       <= prev_next;
      run        <= run_next;
      seq_error  <= seq_error_next;
      err_count  <= err_count_next;
      wrap_count <= wrap_count_next;
      if (sample_en) begin
        valid_code <= legal;
        if (legal) begin
          index <= decoded;
        end
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_sequence_checker.sv
// Directed bench for johnson_sequence_checker: default instance plus a
// no-hold instance and a narrow-counter instance sharing the same stimulus.
module tb_johnson_sequence_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic [3:0] johnson_in = 4'b0000;

  logic [2:0] index0, index1, index2;
  logic       valid0, valid1, valid2;
  logic       locked0, locked1, locked2;
  logic       serr0, serr1, serr2;
  logic [7:0] err0, wrap0, err1, wrap1;
  logic [1:0] err2, wrap2;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] jc [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                         4'b1111, 4'b1110, 4'b1100, 4'b1000};

  always #5 clk = ~clk;

  johnson_sequence_checker dut0 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .johnson_in(johnson_in),
    .index(index0), .valid_code(valid0), .locked(locked0), .seq_error(serr0),
    .err_count(err0), .wrap_count(wrap0)
  );

  johnson_sequence_checker #(.ALLOW_HOLD(1'b0)) dut1 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .johnson_in(johnson_in),
    .index(index1), .valid_code(valid1), .locked(locked1), .seq_error(serr1),
    .err_count(err1), .wrap_count(wrap1)
  );

  johnson_sequence_checker #(.LOCK_COUNT(1), .CNT_WIDTH(2), .ALLOW_HOLD(1'b0)) dut2 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .johnson_in(johnson_in),
    .index(index2), .valid_code(valid2), .locked(locked2), .seq_error(serr2),
    .err_count(err2), .wrap_count(wrap2)
  );

  task automatic step(input logic en, input logic [3:0] code);
    sample_en  = en;
    johnson_in = code;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b0;
    sample_en = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic test_reset;
    sample_en  = 1'b1;
    johnson_in = 4'b0111;
    do_reset(2);
    vectors++; if (index0 !== 3'd0) begin $display("FAIL reset_index got %0d exp 0", index0); miscompares++; end
    vectors++; if (valid0 !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", valid0); miscompares++; end
    vectors++; if (locked0 !== 1'b0) begin $display("FAIL reset_locked got %b exp 0", locked0); miscompares++; end
    vectors++; if (serr0 !== 1'b0) begin $display("FAIL reset_seq_error got %b exp 0", serr0); miscompares++; end
    vectors++; if (err0 !== 8'd0) begin $display("FAIL reset_err_count got %0d exp 0", err0); miscompares++; end
    vectors++; if (wrap0 !== 8'd0) begin $display("FAIL reset_wrap_count got %0d exp 0", wrap0); miscompares++; end
  endtask

  task automatic test_lock;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, jc[i]);
      vectors++; if (locked0 !== (i == 4)) begin $display("FAIL lock_locked[%0d] got %b exp %b", i, locked0, (i == 4)); miscompares++; end
      vectors++; if (serr0 !== 1'b0) begin $display("FAIL lock_seq_error[%0d] got %b exp 0", i, serr0); miscompares++; end
      vectors++; if (index0 !== 3'(i)) begin $display("FAIL lock_index[%0d] got %0d exp %0d", i, index0, i); miscompares++; end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_wrap;
    do_reset(1);
    exp_wrap = 8'd0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, jc[i % 8]);
      if (i >= 5 && (i % 8) == 0) exp_wrap = exp_wrap + 8'd1;
      vectors++; if (index0 !== 3'(i % 8)) begin $display("FAIL wrap_index[%0d] got %0d exp %0d", i, index0, i % 8); miscompares++; end
      vectors++; if (locked0 !== (i >= 4)) begin $display("FAIL wrap_locked[%0d] got %b exp %b", i, locked0, (i >= 4)); miscompares++; end
      vectors++; if (wrap0 !== exp_wrap) begin $display("FAIL wrap_count[%0d] got %0d exp %0d", i, wrap0, exp_wrap); miscompares++; end
    end
    vectors++; if (wrap0 !== 8'd2) begin $display("FAIL wrap_final got %0d exp 2", wrap0); miscompares++; end
  endtask

  task automatic test_skip;
    do_reset(1);
    step(1'b1, jc[7]); step(1'b1, jc[0]); step(1'b1, jc[1]); step(1'b1, jc[2]); step(1'b1, jc[3]);
    vectors++; if (locked0 !== 1'b1 || index0 !== 3'd3) begin $display("FAIL skip_prelock locked=%b index=%0d exp 1/3", locked0, index0); miscompares++; end
    step(1'b1, 4'b1111);
    vectors++; if (serr0 !== 1'b0 || locked0 !== 1'b1) begin $display("FAIL skip_advance seq_error=%b locked=%b exp 0/1", serr0, locked0); miscompares++; end
    step(1'b1, 4'b1000);
    vectors++; if (serr0 !== 1'b1) begin $display("FAIL skip_seq_error got %b exp 1", serr0); miscompares++; end
    vectors++; if (locked0 !== 1'b0) begin $display("FAIL skip_locked got %b exp 0", locked0); miscompares++; end
    vectors++; if (err0 !== 8'd1) begin $display("FAIL skip_err_count got %0d exp 1", err0); miscompares++; end
    vectors++; if (index0 !== 3'd7 || valid0 !== 1'b1) begin $display("FAIL skip_index index=%0d valid=%b exp 7/1", index0, valid0); miscompares++; end
    vectors++; if (wrap0 !== 8'd0) begin $display("FAIL skip_wrap got %0d exp 0", wrap0); miscompares++; end
    step(1'b0, 4'b0000);
    vectors++; if (serr0 !== 1'b0) begin $display("FAIL skip_pulse_width got %b exp 0", serr0); miscompares++; end
  endtask

  task automatic test_illegal;
    step(1'b1, jc[6]); step(1'b1, jc[7]); step(1'b1, jc[0]); step(1'b1, jc[1]); step(1'b1, jc[2]);
    vectors++; if (locked0 !== 1'b1 || index0 !== 3'd2) begin $display("FAIL illegal_prelock locked=%b index=%0d exp 1/2", locked0, index0); miscompares++; end
    step(1'b1, 4'b0101);
    vectors++; if (valid0 !== 1'b0) begin $display("FAIL illegal_valid got %b exp 0", valid0); miscompares++; end
    vectors++; if (index0 !== 3'd2) begin $display("FAIL illegal_index got %0d exp 2", index0); miscompares++; end
    vectors++; if (serr0 !== 1'b1 || locked0 !== 1'b0) begin $display("FAIL illegal_loss seq_error=%b locked=%b exp 1/0", serr0, locked0); miscompares++; end
    vectors++; if (err0 !== 8'd2) begin $display("FAIL illegal_err_count got %0d exp 2", err0); miscompares++; end
    step(1'b1, 4'b0011);
    vectors++; if (serr0 !== 1'b0 || locked0 !== 1'b0 || valid0 !== 1'b1) begin $display("FAIL illegal_restart seq_error=%b locked=%b valid=%b exp 0/0/1", serr0, locked0, valid0); miscompares++; end
    step(1'b1, 4'b1010);
    vectors++; if (valid0 !== 1'b0 || serr0 !== 1'b0 || err0 !== 8'd2) begin $display("FAIL illegal_verify valid=%b seq_error=%b err=%0d exp 0/0/2", valid0, serr0, err0); miscompares++; end
  endtask

  task automatic test_hold;
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b1, jc[i]);
    vectors++; if (locked0 !== 1'b1 || locked1 !== 1'b1) begin $display("FAIL hold_prelock locked0=%b locked1=%b exp 1/1", locked0, locked1); miscompares++; end
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 4'b1111);
      vectors++; if (locked0 !== 1'b1 || serr0 !== 1'b0 || err0 !== 8'd0) begin $display("FAIL hold_allow[%0d] locked=%b seq_error=%b err=%0d exp 1/0/0", r, locked0, serr0, err0); miscompares++; end
      vectors++; if (serr1 !== (r == 0)) begin $display("FAIL hold_strict_seq_error[%0d] got %b exp %b", r, serr1, (r == 0)); miscompares++; end
      vectors++; if (locked1 !== 1'b0 || err1 !== 8'd1) begin $display("FAIL hold_strict_state[%0d] locked=%b err=%0d exp 0/1", r, locked1, err1); miscompares++; end
    end
  endtask

  task automatic test_idle;
    logic [3:0] garbage [10] = '{4'b0101, 4'b1010, 4'b0000, 4'b1001, 4'b0111,
                                 4'b0110, 4'b1011, 4'b1101, 4'b0100, 4'b0010};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, garbage[i]);
      vectors++; if (index0 !== 3'd4 || valid0 !== 1'b1 || locked0 !== 1'b1) begin $display("FAIL idle_hold[%0d] index=%0d valid=%b locked=%b exp 4/1/1", i, index0, valid0, locked0); miscompares++; end
      vectors++; if (serr0 !== 1'b0 || err0 !== 8'd0 || wrap0 !== 8'd0) begin $display("FAIL idle_counts[%0d] seq_error=%b err=%0d wrap=%0d exp 0/0/0", i, serr0, err0, wrap0); miscompares++; end
    end
    sample_en  = 1'b1;
    johnson_in = 4'b1110;
    do_reset(1);
    vectors++; if (index0 !== 3'd0 || valid0 !== 1'b0 || locked0 !== 1'b0) begin $display("FAIL idle_reset index=%0d valid=%b locked=%b exp 0/0/0", index0, valid0, locked0); miscompares++; end
    vectors++; if (serr0 !== 1'b0 || err0 !== 8'd0 || wrap0 !== 8'd0) begin $display("FAIL idle_reset_counts seq_error=%b err=%0d wrap=%0d exp 0/0/0", serr0, err0, wrap0); miscompares++; end
    step(1'b0, 4'b0000);
    vectors++; if (serr0 !== 1'b0) begin $display("FAIL idle_reset_pulse got %b exp 0", serr0); miscompares++; end
  endtask

  task automatic test_saturate;
    logic [1:0] exp_wrap;
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, jc[0]);
      step(1'b1, jc[1]);
      vectors++; if (locked2 !== 1'b1) begin $display("FAIL sat_locked[%0d] got %b exp 1", k, locked2); miscompares++; end
      step(1'b1, jc[1]);
      vectors++; if (serr2 !== 1'b1) begin $display("FAIL sat_seq_error[%0d] got %b exp 1", k, serr2); miscompares++; end
      vectors++; if (err2 !== ((k < 3) ? 2'(k + 1) : 2'd3)) begin $display("FAIL sat_err_count[%0d] got %0d exp %0d", k, err2, (k < 3) ? k + 1 : 3); miscompares++; end
    end
    do_reset(1);
    step(1'b1, jc[0]);
    step(1'b1, jc[1]);
    exp_wrap = 2'd0;
    for (int j = 2; j < 42; j++) begin
      step(1'b1, jc[j % 8]);
      if ((j % 8) == 0) exp_wrap = exp_wrap + 2'd1;
    end
    vectors++; if (wrap2 !== exp_wrap || wrap2 !== 2'd1) begin $display("FAIL sat_wrap_modulo got %0d exp 1", wrap2); miscompares++; end
    vectors++; if (locked2 !== 1'b1 || err2 !== 2'd0) begin $display("FAIL sat_wrap_state locked=%b err=%0d exp 1/0", locked2, err2); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_skip();
    test_illegal();
    test_hold();
    test_idle();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
